// File: rtl/aic1106_pkg.sv
// Shared constants and types for the AIC1106 receive path: register map,
// STATUS/CONTROL bit positions and the 32-bit stereo sample word.
package aic1106_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;

   localparam int STAT_EMPTY_BIT = 16;
   localparam int STAT_FULL_BIT  = 17;
   localparam int STAT_OVF_BIT   = 18;
   localparam int STAT_UDR_BIT   = 19;
   localparam int STAT_DROP_LSB  = 24;

   localparam int CTRL_FLUSH_BIT = 0;
   localparam int CTRL_EN_BIT    = 1;
   localparam int CTRL_IRQEN_BIT = 2;
   localparam int CTRL_THR_LSB   = 8;
   localparam int THR_W          = 8;

   localparam int DROP_W = 8;
   localparam logic [DROP_W-1:0] DROP_MAX = 8'hFF;

   // [15:0] first channel, [31:16] second channel
   typedef struct packed {
      logic [15:0] ch1;
      logic [15:0] ch0;
   } aic1106_sample_t;

   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
      logic [DROP_W-1:0] r;
      if (v == DROP_MAX) begin
         r = v;
      end else begin
         r = v + 8'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/aic1106_sync_fifo.sv
// Synchronous FIFO with occupancy count; push/pop arrive pre-qualified from
// the register block and flush overrides both.
module aic1106_sync_fifo
   import aic1106_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic            pop,
   input  logic            flush,
   input  aic1106_sample_t wdata,
   output aic1106_sample_t rdata,
   output logic [AW:0]     level,
   output logic            full,
   output logic            empty
);

   aic1106_sample_t mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     level_q, level_d;

   // Next pointer/level; flush wins over any same-cycle push or pop
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
         endcase
      end
   end

   // Pointer and level state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Sample storage, intentionally unreset
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign level = level_q;
   assign full  = (level_q == (AW+1)'(DEPTH));
   assign empty = (level_q == '0);

endmodule

// File: rtl/aic1106_rx_fifo.sv
// AIC1106 receive sample buffer: Avalon-ST capture into a FIFO, Avalon-MM
// DATA/STATUS/CONTROL slave. Define AIC1106_RX_IRQ_EN for the level IRQ.
module aic1106_rx_fifo
   import aic1106_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic        csi_clk,
   input  logic        csi_reset,
   input  logic [31:0] asi_data,
   input  logic        asi_valid,
   input  logic [1:0]  avs_s_address,
   input  logic        avs_s_chipselect,
   input  logic        avs_s_read,
   input  logic        avs_s_write,
   input  logic [31:0] avs_s_writedata,
   output logic [31:0] avs_s_readdata,
   output logic        ins_irq
);

   aic1106_sample_t   head_s;
   logic [AW:0]       level_s;
   logic              full_s, empty_s;
   logic              rd_s, wr_s, data_rd_s, status_wr_s, ctrl_wr_s;
   logic              flush_s, pop_s, push_s, drop_s, clear_ovf_s;
   logic [31:0]       status_s, ctrl_s, rdmux_s;
   logic [DROP_W-1:0] drop_base_s;

   logic              enable_q, enable_d;
   logic              overflow_q, overflow_d;
   logic              underrun_q, underrun_d;
   logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
   logic [31:0]       readdata_q, readdata_d;

   assign rd_s        = avs_s_chipselect & avs_s_read;
   assign wr_s        = avs_s_chipselect & avs_s_write;
   assign data_rd_s   = rd_s & (avs_s_address == ADDR_DATA);
   assign status_wr_s = wr_s & (avs_s_address == ADDR_STATUS);
   assign ctrl_wr_s   = wr_s & (avs_s_address == ADDR_CTRL);
   assign flush_s     = ctrl_wr_s & avs_s_writedata[CTRL_FLUSH_BIT];
   assign clear_ovf_s = status_wr_s & avs_s_writedata[STAT_OVF_BIT];

   // A same-cycle pop frees the slot, so a push into a full FIFO still lands
   assign pop_s  = data_rd_s & ~empty_s;
   assign push_s = asi_valid & enable_q & ~flush_s & (~full_s | pop_s);
   assign drop_s = asi_valid & enable_q & ~flush_s & full_s & ~pop_s;

   aic1106_sync_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk   (csi_clk),
      .rst   (csi_reset),
      .push  (push_s),
      .pop   (pop_s),
      .flush (flush_s),
      .wdata (aic1106_sample_t'(asi_data)),
      .rdata (head_s),
      .level (level_s),
      .full  (full_s),
      .empty (empty_s)
   );

`ifdef AIC1106_RX_IRQ_EN
   logic             irq_en_q, irq_en_d;
   logic [THR_W-1:0] threshold_q, threshold_d;
   logic             irq_q, irq_d;

   // Threshold compare in 9 bits so thresholds above DEPTH can never match
   always_comb begin
      if (ctrl_wr_s) begin
         irq_en_d    = avs_s_writedata[CTRL_IRQEN_BIT];
         threshold_d = avs_s_writedata[CTRL_THR_LSB +: THR_W];
      end else begin
         irq_en_d    = irq_en_q;
         threshold_d = threshold_q;
      end
      irq_d = irq_en_q && (threshold_q != 8'd0) && (9'(level_s) >= {1'b0, threshold_q});
   end

   // Interrupt configuration and output register
   always_ff @(posedge csi_clk or posedge csi_reset) begin
      if (csi_reset) begin
         irq_en_q    <= 1'b0;
         threshold_q <= 8'd0;
         irq_q       <= 1'b0;
      end else begin
         irq_en_q    <= irq_en_d;
         threshold_q <= threshold_d;
         irq_q       <= irq_d;
      end
   end

   assign ins_irq = irq_q;
`else
   assign ins_irq = 1'b0;
`endif

   // STATUS / CONTROL read images and the read mux
   always_comb begin
      status_s = 32'd0;
      status_s[AW:0]                          = level_s;
      status_s[STAT_EMPTY_BIT]                = empty_s;
      status_s[STAT_FULL_BIT]                 = full_s;
      status_s[STAT_OVF_BIT]                  = overflow_q;
      status_s[STAT_UDR_BIT]                  = underrun_q;
      status_s[STAT_DROP_LSB +: DROP_W]       = drop_cnt_q;
      ctrl_s = 32'd0;
      ctrl_s[CTRL_EN_BIT]                     = enable_q;
`ifdef AIC1106_RX_IRQ_EN
      ctrl_s[CTRL_IRQEN_BIT]                  = irq_en_q;
      ctrl_s[CTRL_THR_LSB +: THR_W]           = threshold_q;
`endif
      case (avs_s_address)
         ADDR_DATA:   rdmux_s = empty_s ? 32'd0 : 32'(head_s);
         ADDR_STATUS: rdmux_s = status_s;
         ADDR_CTRL:   rdmux_s = ctrl_s;
         default:     rdmux_s = 32'd0;
      endcase
   end

   // Flag and control next-state; a new event beats a same-cycle W1C
   always_comb begin
      if (ctrl_wr_s) begin
         enable_d = avs_s_writedata[CTRL_EN_BIT];
      end else begin
         enable_d = enable_q;
      end
      drop_base_s = clear_ovf_s ? {DROP_W{1'b0}} : drop_cnt_q;
      drop_cnt_d  = drop_s ? sat_inc(drop_base_s) : drop_base_s;
      overflow_d  = drop_s | (overflow_q & ~clear_ovf_s);
      underrun_d  = (data_rd_s & empty_s) |
                    (underrun_q & ~(status_wr_s & avs_s_writedata[STAT_UDR_BIT]));
      if (rd_s) begin
         readdata_d = rdmux_s;
      end else begin
         readdata_d = readdata_q;
      end
   end

   // Register file state
   always_ff @(posedge csi_clk or posedge csi_reset) begin
      if (csi_reset) begin
         enable_q   <= 1'b0;
         overflow_q <= 1'b0;
         underrun_q <= 1'b0;
         drop_cnt_q <= 8'd0;
         readdata_q <= 32'd0;
      end else begin
         enable_q   <= enable_d;
         overflow_q <= overflow_d;
         underrun_q <= underrun_d;
         drop_cnt_q <= drop_cnt_d;
         readdata_q <= readdata_d;
      end
   end

   assign avs_s_readdata = readdata_q;

   logic unused_s;
   assign unused_s = ^avs_s_writedata;

endmodule

// File: tb/tb_aic1106_rx_fifo.sv
// Directed bench for aic1106_rx_fifo at DEPTH = 4; the IRQ checks follow
// AIC1106_RX_IRQ_EN the same way the design does.
module tb_aic1106_rx_fifo;
   import aic1106_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] asi_data;
   logic        asi_valid;
   logic [1:0]  addr;
   logic        cs, rd, wr;
   logic [31:0] wdata;
   logic [31:0] readdata;
   logic        irq;

   int n_total = 0;
   int n_pass  = 0;

   aic1106_rx_fifo #(.DEPTH(4)) dut (
      .csi_clk          (clk),
      .csi_reset        (rst),
      .asi_data         (asi_data),
      .asi_valid        (asi_valid),
      .avs_s_address    (addr),
      .avs_s_chipselect (cs),
      .avs_s_read       (rd),
      .avs_s_write      (wr),
      .avs_s_writedata  (wdata),
      .avs_s_readdata   (readdata),
      .ins_irq          (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  a;
      logic        r;
      logic        w;
      logic [31:0] wd;
      logic        v;
      logic [31:0] sd;
      logic        chk;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic [1:0] a, logic r, logic w, logic [31:0] wd,
                               logic v, logic [31:0] sd, logic chk, logic [31:0] exp,
                               string name);
      vec_t t;
      t.a = a; t.r = r; t.w = w; t.wd = wd; t.v = v; t.sd = sd;
      t.chk = chk; t.exp = exp; t.name = name;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // One bus/stream cycle; outputs are stable at #1 after the edge
   task automatic cyc(input logic [1:0] a, input logic r, input logic w,
                      input logic [31:0] wd, input logic v, input logic [31:0] sd);
      addr = a; rd = r; wr = w; cs = r | w; wdata = wd; asi_valid = v; asi_data = sd;
      @(posedge clk);
      #1;
      cs = 1'b0; rd = 1'b0; wr = 1'b0; asi_valid = 1'b0; wdata = 32'd0;
   endtask

   task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string name);
      cyc(a, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      check(name, readdata, exp);
   endtask

   task automatic push(input logic [31:0] d);
      cyc(ADDR_DATA, 1'b0, 1'b0, 32'd0, 1'b1, d);
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
      cyc(a, 1'b0, 1'b1, d, 1'b0, 32'd0);
   endtask

   initial begin
      rst = 1'b1; asi_data = 32'd0; asi_valid = 1'b0; addr = 2'd0;
      cs = 1'b0; rd = 1'b0; wr = 1'b0; wdata = 32'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_readdata", readdata, 32'd0);

      vecs.push_back(mk(ADDR_STATUS, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h0001_0000, "rst_status"));
      vecs.push_back(mk(ADDR_CTRL,   1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h0000_0000, "rst_ctrl"));
      vecs.push_back(mk(ADDR_DATA,   1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h0000_0000, "empty_data"));
      vecs.push_back(mk(ADDR_STATUS, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h0009_0000, "underrun_set"));
      vecs.push_back(mk(ADDR_STATUS, 1'b0, 1'b1, 32'h0008_0000, 1'b0, 32'd0, 1'b0, 32'd0, "udr_w1c"));
      vecs.push_back(mk(ADDR_CTRL,   1'b0, 1'b1, 32'h0000_0002, 1'b0, 32'd0, 1'b0, 32'd0, "enable"));
      vecs.push_back(mk(ADDR_CTRL,   1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h0000_0002, "ctrl_en"));
      vecs.push_back(mk(ADDR_DATA,   1'b0, 1'b0, 32'd0, 1'b1, 32'h1111_2222, 1'b0, 32'd0, "push1"));
      vecs.push_back(mk(ADDR_DATA,   1'b0, 1'b0, 32'd0, 1'b1, 32'h3333_4444, 1'b0, 32'd0, "push2"));
      vecs.push_back(mk(ADDR_STATUS, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h0000_0002, "level2"));
      vecs.push_back(mk(ADDR_DATA,   1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h1111_2222, "pop1"));
      vecs.push_back(mk(ADDR_STATUS, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h0000_0001, "level1"));
      vecs.push_back(mk(ADDR_DATA,   1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h3333_4444, "pop2"));
      vecs.push_back(mk(ADDR_STATUS, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h0001_0000, "empty_again"));
      for (int i = 0; i < 6; i++) begin
         vecs.push_back(mk(ADDR_DATA, 1'b0, 1'b0, 32'd0, 1'b1, 32'hA000_0000 + 32'(i), 1'b0, 32'd0, "ovf_push"));
      end
      vecs.push_back(mk(ADDR_STATUS, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h0206_0004, "full_ovf_drop2"));
      for (int i = 0; i < 4; i++) begin
         vecs.push_back(mk(ADDR_DATA, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hA000_0000 + 32'(i), "ovf_pop"));
      end
      vecs.push_back(mk(ADDR_STATUS, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h0205_0000, "ovf_sticky"));
      vecs.push_back(mk(ADDR_STATUS, 1'b0, 1'b1, 32'h0004_0000, 1'b0, 32'd0, 1'b0, 32'd0, "ovf_w1c"));
      vecs.push_back(mk(ADDR_STATUS, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h0001_0000, "ovf_cleared"));
      vecs.push_back(mk(ADDR_DATA,   1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h0000_0000, "empty_data2"));
      vecs.push_back(mk(ADDR_STATUS, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h0009_0000, "underrun2"));

      foreach (vecs[i]) begin
         cyc(vecs[i].a, vecs[i].r, vecs[i].w, vecs[i].wd, vecs[i].v, vecs[i].sd);
         if (vecs[i].chk) begin
            check(vecs[i].name, readdata, vecs[i].exp);
         end
      end

      // Full FIFO: push and pop in the same cycle
      for (int i = 0; i < 4; i++) push(32'hB000_0000 + 32'(i));
      cyc(ADDR_DATA, 1'b1, 1'b0, 32'd0, 1'b1, 32'hB000_0004);
      check("simul_pop_head", readdata, 32'hB000_0000);
      rd_chk(ADDR_STATUS, 32'h000A_0004, "simul_no_ovf");
      for (int i = 1; i < 5; i++) rd_chk(ADDR_DATA, 32'hB000_0000 + 32'(i), "simul_order");
      rd_chk(ADDR_STATUS, 32'h0009_0000, "simul_empty");

      // Level interrupt
      wr_reg(ADDR_CTRL, 32'h0000_0306);
`ifdef AIC1106_RX_IRQ_EN
      rd_chk(ADDR_CTRL, 32'h0000_0306, "ctrl_irq_cfg");
      push(32'hC000_0000);
      push(32'hC000_0001);
      push(32'hC000_0002);
      check("irq_not_yet", {31'd0, irq}, 32'd0);
      cyc(ADDR_DATA, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      check("irq_rise", {31'd0, irq}, 32'd1);
      rd_chk(ADDR_DATA, 32'hC000_0000, "irq_pop");
      check("irq_hold", {31'd0, irq}, 32'd1);
      cyc(ADDR_DATA, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      check("irq_fall", {31'd0, irq}, 32'd0);
`else
      rd_chk(ADDR_CTRL, 32'h0000_0002, "ctrl_no_irq");
      push(32'hC000_0000);
      push(32'hC000_0001);
      push(32'hC000_0002);
      cyc(ADDR_DATA, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      check("irq_tied_low", {31'd0, irq}, 32'd0);
      rd_chk(ADDR_DATA, 32'hC000_0000, "irq_pop");
`endif
      wr_reg(ADDR_CTRL, 32'h0000_0002);
      push(32'hC000_0003);
      rd_chk(ADDR_STATUS, 32'h0008_0003, "three_queued");

      // Flush with a same-cycle push
      cyc(ADDR_CTRL, 1'b0, 1'b1, 32'h0000_0003, 1'b1, 32'hDEAD_BEEF);
      rd_chk(ADDR_STATUS, 32'h0009_0000, "flush_status");
      rd_chk(ADDR_CTRL, 32'h0000_0002, "flush_selfclr");
      push(32'h1234_5678);
      rd_chk(ADDR_DATA, 32'h1234_5678, "post_flush_pop");

      // Disabled pushes vanish without flags
      wr_reg(ADDR_CTRL, 32'h0000_0000);
      push(32'h5555_5555);
      rd_chk(ADDR_STATUS, 32'h0009_0000, "disabled_push");

      // Asynchronous reset mid-fill
      wr_reg(ADDR_CTRL, 32'h0000_0002);
      push(32'h7777_0001);
      push(32'h7777_0002);
      rd_chk(ADDR_DATA, 32'h7777_0001, "pre_reset_pop");
      #2 rst = 1'b1;
      #1;
      check("async_rst_readdata", readdata, 32'd0);
      check("async_rst_irq", {31'd0, irq}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      rd_chk(ADDR_STATUS, 32'h0001_0000, "post_rst_status");
      rd_chk(ADDR_CTRL, 32'h0000_0000, "post_rst_ctrl");
      rd_chk(ADDR_DATA, 32'h0000_0000, "post_rst_data");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
